// File: rtl/ads4226_cap_pkg.sv
// Shared types for the ADS4226 capture engine: FSM states and trigger
// selector encodings.
package ads4226_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST,
    READOUT
  } cap_state_t;

  localparam logic TRIG_RISE  = 1'b0;
  localparam logic TRIG_FALL  = 1'b1;
  localparam logic TRIG_SRC_A = 1'b0;
  localparam logic TRIG_SRC_B = 1'b1;

endpackage

// File: rtl/ads4226_capture_if.sv
// Record readout stream: {B, A} words with a last-word marker, valid/ready
// flow control.
interface ads4226_capture_if #(
  parameter int DATA_WIDTH = 12
);
  logic [2*DATA_WIDTH-1:0] Rd_Data;
  logic                    Rd_Valid;
  logic                    Rd_Ready;
  logic                    Rd_Last;

  modport master (output Rd_Data, output Rd_Valid, output Rd_Last, input Rd_Ready);
  modport slave  (input Rd_Data, input Rd_Valid, input Rd_Last, output Rd_Ready);
endinterface

// File: rtl/ads4226_sample_ram.sv
// Simple dual-port sample store: one write port, one read port with a
// registered output (one cycle of read latency).
module ads4226_sample_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ads4226_capture.sv
// Triggered capture of ADS4226 channel A/B samples into a circular record,
// followed by an in-order readout through a two-entry skid buffer.
module ads4226_capture
  import ads4226_cap_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH_LOG2  = 10,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   AD_CLKOUT,
  input  logic                   AD_RST,
  input  logic [DATA_WIDTH-1:0]  AD_DA,
  input  logic [DATA_WIDTH-1:0]  AD_DB,
  input  logic                   Arm,
  input  logic                   Force_Trig,
  input  logic                   Trig_Sel,
  input  logic                   Trig_Edge,
  input  logic [DATA_WIDTH-1:0]  Trig_Level,
  input  logic [DEPTH_LOG2-1:0]  Pre_Len,
  input  logic [DECIM_WIDTH-1:0] Decim,
  output logic                   Busy,
  output logic                   Triggered,
  ads4226_capture_if.master      rd
);

  localparam int WORD_W  = 2 * DATA_WIDTH;
  localparam int ENTRY_W = WORD_W + 1;

  cap_state_t                   state;
  logic [DATA_WIDTH-1:0]        da_q, db_q;
  logic                         stb_q;
  logic [DECIM_WIDTH-1:0]       dec_cnt;
  logic                         trig_sel, trig_edge;
  logic signed [DATA_WIDTH-1:0] trig_level, prev_s;
  logic [DEPTH_LOG2-1:0]        pre_len;
  logic [DECIM_WIDTH-1:0]       decim;
  logic [DEPTH_LOG2-1:0]        wr_ptr, pre_cnt, post_cnt, trig_addr;
  logic                         prev_valid, force_pend;
  logic [DEPTH_LOG2:0]          rd_cnt;
  logic                         rd_pend, rd_pend_last;
  logic [WORD_W-1:0]            ram_q;
  logic [ENTRY_W-1:0]           skid0, skid1;
  logic [1:0]                   skid_cnt;

  logic                         capturing, wr_en, level_hit, trig_hit;
  logic                         pop, rd_issue, rd_done;
  logic signed [DATA_WIDTH-1:0] cur_s;
  logic [1:0]                   occ;
  logic [DEPTH_LOG2-1:0]        rd_addr;

  assign rd.Rd_Valid = (skid_cnt != 2'd0);
  assign rd.Rd_Data  = skid0[WORD_W-1:0];
  assign rd.Rd_Last  = skid0[WORD_W] && rd.Rd_Valid;

  always_comb begin
    capturing = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
    wr_en     = stb_q && capturing;
    cur_s     = (trig_sel == TRIG_SRC_B) ? db_q : da_q;
    if (trig_edge == TRIG_RISE)
      level_hit = prev_valid && (prev_s < trig_level) && (cur_s >= trig_level);
    else
      level_hit = prev_valid && (prev_s >= trig_level) && (cur_s < trig_level);
    trig_hit  = wr_en && (state == WAIT_TRIG) && (level_hit || force_pend || Force_Trig);
    pop       = rd.Rd_Valid && rd.Rd_Ready;
    // Words held plus the one in flight from the RAM must never exceed two.
    occ       = skid_cnt + {1'b0, rd_pend};
    rd_done   = rd_cnt[DEPTH_LOG2];
    rd_issue  = (state == READOUT) && !rd_done &&
                ((occ < 2'd2) || (pop && (occ == 2'd2)));
    rd_addr   = trig_addr - pre_len + rd_cnt[DEPTH_LOG2-1:0];
  end

  // The strobe is computed for the sample on the pins and travels with it.
  always_ff @(posedge AD_CLKOUT) begin
    da_q <= AD_DA;
    db_q <= AD_DB;
  end

  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates see the values from before the clock edge.
  always_ff @(posedge AD_CLKOUT) begin
    if (AD_RST) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Triggered  <= 1'b0;
      stb_q      <= 1'b0;
      dec_cnt    <= '0;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      prev_valid <= 1'b0;
      prev_s     <= '0;
      force_pend <= 1'b0;
      rd_cnt     <= '0;
      trig_sel   <= TRIG_SRC_A;
      trig_edge  <= TRIG_RISE;
      trig_level <= '0;
      pre_len    <= '0;
      decim      <= '0;
    end else begin
      stb_q <= capturing && (dec_cnt == '0);
      if (capturing) dec_cnt <= (dec_cnt == decim) ? '0 : dec_cnt + 1'b1;
      if (wr_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev_s     <= cur_s;
        prev_valid <= 1'b1;
      end
      if (rd_issue) rd_cnt <= rd_cnt + 1'b1;

      unique case (state)
        IDLE: if (Arm) begin
          trig_sel   <= Trig_Sel;
          trig_edge  <= Trig_Edge;
          trig_level <= Trig_Level;
          pre_len    <= Pre_Len;
          decim      <= Decim;
          wr_ptr     <= '0;
          pre_cnt    <= '0;
          dec_cnt    <= '0;
          rd_cnt     <= '0;
          prev_valid <= 1'b0;
          force_pend <= 1'b0;
          Busy       <= 1'b1;
          Triggered  <= 1'b0;
          state      <= (Pre_Len == '0) ? WAIT_TRIG : PRE_FILL;
        end
        PRE_FILL: if (wr_en) begin
          pre_cnt <= pre_cnt + 1'b1;
          if (pre_cnt == pre_len - 1'b1) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (Force_Trig) force_pend <= 1'b1;
          if (trig_hit) begin
            trig_addr  <= wr_ptr;
            post_cnt   <= ~pre_len;
            Triggered  <= 1'b1;
            force_pend <= 1'b0;
            if (pre_len == '1) begin
              state <= READOUT;
              Busy  <= 1'b0;
            end else begin
              state <= POST;
            end
          end
        end
        POST: if (wr_en) begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == DEPTH_LOG2'(1)) begin
            state <= READOUT;
            Busy  <= 1'b0;
          end
        end
        READOUT: if (pop && rd.Rd_Last) begin
          state     <= IDLE;
          Triggered <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge AD_CLKOUT) begin
    if (AD_RST) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      skid0        <= '0;
      skid1        <= '0;
      skid_cnt     <= 2'd0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_cnt[DEPTH_LOG2-1:0] == '1);
      unique case (skid_cnt)
        2'd0: if (rd_pend) begin
          skid0    <= {rd_pend_last, ram_q};
          skid_cnt <= 2'd1;
        end
        2'd1: begin
          if (rd_pend && pop) begin
            skid0 <= {rd_pend_last, ram_q};
          end else if (rd_pend) begin
            skid1    <= {rd_pend_last, ram_q};
            skid_cnt <= 2'd2;
          end else if (pop) begin
            skid_cnt <= 2'd0;
          end
        end
        2'd2: if (pop) begin
          skid0 <= skid1;
          if (rd_pend) skid1 <= {rd_pend_last, ram_q};
          else         skid_cnt <= 2'd1;
        end
        default: skid_cnt <= 2'd0;
      endcase
    end
  end

  ads4226_sample_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk   (AD_CLKOUT),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({db_q, da_q}),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

endmodule
